// File: rtl/clk_ratio_ctrl_if.sv
// Ratio-change request handshake between a configuration master and clk_ratio_ctrl.
// A request is taken in the cycle where cfg_valid and cfg_ready are both high.
interface clk_ratio_ctrl_if #(
  parameter int CNT_W = 6
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_ratio;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_ratio, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready);
endinterface

// File: rtl/clk_ratio_ctrl.sv
// Fast/slow clock-phase sequencer with a programmable slow half-period.
// Ratio changes wait for the end of a full slow period, then a short frozen gap.
module clk_ratio_ctrl #(
  parameter int CNT_W         = 6,
  parameter int DEFAULT_RATIO = 5,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  clk_ratio_ctrl_if.slave      cfg,
  output logic                 fast_phase,
  output logic                 slow_phase,
  output logic                 slow_tick,
  output logic                 hold,
  output logic [CNT_W-1:0]     cur_ratio
);

  localparam int SW_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWITCH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic             fast_q, fast_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
  logic             hold_q, hold_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             period_end;

  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
    return (r == '0) ? CNT_W'(1) : r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    sw_d       = sw_q;
    fast_d     = fast_q;
    slow_d     = slow_q;
    tick_d     = 1'b0;
    accept     = cfg.cfg_valid && ready_q;
    period_end = (cnt_q == cur_q - CNT_W'(1));

    case (state_q)
      IDLE: begin
        // A ratio write in IDLE takes priority over leaving for RUN.
        if (accept)      cur_d   = clamp_ratio(cfg.cfg_ratio);
        else if (enable) state_d = RUN;
      end
      RUN, DRAIN: begin
        fast_d = ~fast_q;
        if (period_end) begin
          cnt_d  = '0;
          slow_d = ~slow_q;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == RUN) begin
          if (accept) begin
            pend_d  = clamp_ratio(cfg.cfg_ratio);
            state_d = DRAIN;
          end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            fast_d  = 1'b1;
            slow_d  = 1'b0;
            tick_d  = 1'b0;
          end
        end else if (period_end && slow_q) begin
          // Falling slow edge closes a full period: safe point to swap ratio.
          state_d = SWITCH;
          sw_d    = '0;
        end
      end
      SWITCH: begin
        if (sw_q == SW_W'(DRAIN_CYCLES - 1)) begin
          cur_d   = pend_q;
          cnt_d   = '0;
          fast_d  = 1'b1;
          slow_d  = 1'b0;
          state_d = enable ? RUN : IDLE;
        end else begin
          sw_d = sw_q + SW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    hold_d  = (state_d == DRAIN) || (state_d == SWITCH);
    ready_d = ((state_d == IDLE) || (state_d == RUN)) && !accept;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= CNT_W'(DEFAULT_RATIO);
      pend_q  <= CNT_W'(DEFAULT_RATIO);
      sw_q    <= '0;
      fast_q  <= 1'b1;
      slow_q  <= 1'b0;
      tick_q  <= 1'b0;
      hold_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      sw_q    <= sw_d;
      fast_q  <= fast_d;
      slow_q  <= slow_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
    end
  end

  assign fast_phase    = fast_q;
  assign slow_phase    = slow_q;
  assign slow_tick     = tick_q;
  assign hold          = hold_q;
  assign cur_ratio     = cur_q;
  assign cfg.cfg_ready = ready_q;

endmodule
